stream_ddr_burst_writer: RTL and testbench
==========================================

Name: stream_ddr_burst_writer

Overview:
- Sits directly upstream of the HPS SDRAM interface of soc_system, on the f2h_sdram Avalon-MM write port.
- Accepts a 32-bit Avalon-ST sample stream, buffers it in an internal FIFO, and writes fixed-length bursts into a circular buffer in DDR3.
- Reports progress counters that the HPS software polls to locate fresh data.

Parameters:
- DATA_W, 32, stream and memory data width in bits (byte-lane count = DATA_W/8).
- BURST_LEN, 8, beats per Avalon burst; power of two, 2..64.
- FIFO_AW, 6, FIFO address width; depth = 2**FIFO_AW, must be >= 2*BURST_LEN.

Ports:
- clk_clk  in  1  single clock; same clock as soc_system clk_clk.
- reset_reset  in  1  asynchronous, active-high reset.
- cfg_enable  in  1  run/stop control.
- cfg_base_addr  in  32  byte address of buffer start; aligned to BURST_LEN*DATA_W/8.
- cfg_num_bursts  in  16  buffer size in bursts; 0 is treated as 1.
- snk_data  in  DATA_W  stream sample.
- snk_valid  in  1  sample valid.
- snk_ready  out  1  sample accepted when valid && ready.
- avm_address  out  32  burst start byte address.
- avm_write  out  1  write request.
- avm_writedata  out  DATA_W  beat data.
- avm_byteenable  out  DATA_W/8  always all ones.
- avm_burstcount  out  clog2(BURST_LEN)+1  always BURST_LEN.
- avm_waitrequest  in  1  slave stall.
- sts_burst_idx  out  16  index of the next burst slot to be written.
- sts_wrap_count  out  16  number of completed passes through the buffer.
- sts_busy  out  1  high while not in IDLE.

Behaviour:
- Reset (async assert, sync deassert) drives:
  - FSM to IDLE, FIFO empty.
  - snk_ready=0, avm_write=0, avm_address=0, avm_writedata=0.
  - sts_burst_idx=0, sts_wrap_count=0, sts_busy=0.
  - avm_byteenable is constant all ones; avm_burstcount is constant BURST_LEN.
- FIFO:
  - Synchronous write, first-word-fall-through read, occupancy counter of FIFO_AW+1 bits.
  - snk_ready = (state != IDLE) && !full. No sample is ever dropped; upstream is backpressured.
  - A simultaneous push and pop leaves the count unchanged. Push is never granted when full; pop never happens when empty.
- FSM states:
  - IDLE: FIFO flushed, sts_burst_idx cleared to 0.
    - On cfg_enable=1, latch cfg_base_addr and max(cfg_num_bursts,1) and go to FILL.
    - sts_wrap_count is cleared only by reset.
  - FILL:
    - If cfg_enable=0, go to IDLE. Residual FIFO data (<BURST_LEN words) is discarded.
    - Else if count >= BURST_LEN, go to BURST.
    - avm_address is registered as base + sts_burst_idx*BURST_LEN*(DATA_W/8), 32-bit wrap.
  - BURST:
    - avm_write=1 and avm_address is held constant for all beats.
    - avm_writedata = FIFO head. A beat completes on avm_write && !avm_waitrequest, which pops the FIFO and increments a beat counter.
    - avm_write must never drop mid-burst; the FIFO is guaranteed to hold BURST_LEN words at entry.
    - On the last beat, the next cycle is FILL with avm_write=0.
    - On the last beat, sts_burst_idx increments. At latched_num_bursts-1 it wraps to 0 and sts_wrap_count increments (16-bit wrap).
    - cfg_enable=0 during BURST: the burst completes normally, then FILL sees enable low and goes to IDLE. Bursts are never truncated.
- Latency:
  - The BURST_LEN-th sample is accepted at edge k with the FSM in FILL.
  - count is visible after k; the FSM enters BURST at edge k+1; avm_write is high in the cycle after k+1.
  - With no waitrequest, one burst occupies exactly BURST_LEN cycles, followed by at least 1 FILL cycle.
- cfg_* changes take effect only on the next IDLE->FILL transition.
- avm_waitrequest held high indefinitely: outputs hold stable and the FIFO fills, then snk_ready deasserts.
- Reset mid-burst: immediate return to reset values. A partial burst on the bus is acceptable; the interconnect is reset together with this block.
- sts_busy = (state != IDLE).

Test Plan:
- Enable with base=0x3000_0000, num_bursts=4, BURST_LEN=8, and stream 0..31 with continuous valid:
  - 4 bursts at 0x3000_0000, 0x3000_0020, 0x3000_0040, 0x3000_0060.
  - Data 0..31 in order, burstcount=8, byteenable=0xF.
  - sts_burst_idx ends at 0, sts_wrap_count=1.
- Stream 40 words with num_bursts=4:
  - Fifth burst returns to 0x3000_0000 carrying words 32..39; sts_burst_idx=1.
- Random avm_waitrequest (50%) during 16 words:
  - Address and writedata stable while stalled; exactly 16 accepted beats, in order, no duplicates.
- Hold waitrequest high while streaming 100 words with FIFO_AW=6:
  - snk_ready falls after 64 accepted words (FIFO full).
  - After release, all 64 are written in order.
- Drop cfg_enable at beat 3 of a burst with 5 residual FIFO words:
  - Burst completes all 8 beats, then IDLE.
  - Residual FIFO words discarded; sts_burst_idx=0, sts_busy=0.
- Assert reset_reset mid-burst (asynchronously, between edges):
  - avm_write and snk_ready drop to 0 immediately; status counters read 0.

Source files
------------

// File: rtl/stream_ddr_burst_writer.sv
// Streams Avalon-ST samples through a FWFT FIFO into fixed-length Avalon-MM write
// bursts that walk a circular buffer in DDR, reporting slot index and wrap count.
module stream_ddr_burst_writer #(
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 8,
    parameter int FIFO_AW   = 6
) (
    input  logic                         clk_clk,
    input  logic                         reset_reset,
    input  logic                         cfg_enable,
    input  logic [31:0]                  cfg_base_addr,
    input  logic [15:0]                  cfg_num_bursts,
    input  logic [DATA_W-1:0]            snk_data,
    input  logic                         snk_valid,
    output logic                         snk_ready,
    output logic [31:0]                  avm_address,
    output logic                         avm_write,
    output logic [DATA_W-1:0]            avm_writedata,
    output logic [DATA_W/8-1:0]          avm_byteenable,
    output logic [$clog2(BURST_LEN):0]   avm_burstcount,
    input  logic                         avm_waitrequest,
    output logic [15:0]                  sts_burst_idx,
    output logic [15:0]                  sts_wrap_count,
    output logic                         sts_busy
);
    localparam int DEPTH  = 2**FIFO_AW;
    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam int BC_W   = BEAT_W + 1;
    localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * (DATA_W/8));

    // state | meaning
    // IDLE  | stopped, FIFO flushed, slot index cleared
    // FILL  | collecting samples until a full burst is buffered
    // BURST | issuing one BURST_LEN-beat write burst
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_BURST = 2'd2;

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic [1:0]         state_q, state_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [31:0]        base_q, base_d;
    logic [15:0]        num_q, num_d;
    logic [15:0]        idx_q, idx_d;
    logic [15:0]        wrap_q, wrap_d;
    logic [31:0]        addr_q, addr_d;

    logic full, push, pop, last_beat;

    assign full      = (count_q == (FIFO_AW+1)'(DEPTH));
    assign snk_ready = (state_q != S_IDLE) && !full;
    assign push      = snk_valid && snk_ready;
    assign avm_write = (state_q == S_BURST);
    assign pop       = avm_write && !avm_waitrequest;
    assign last_beat = pop && (beat_q == BEAT_W'(BURST_LEN-1));

    assign avm_address    = addr_q;
    assign avm_writedata  = avm_write ? mem_q[rd_ptr_q] : '0;
    assign avm_byteenable = '1;
    assign avm_burstcount = BC_W'(BURST_LEN);
    assign sts_burst_idx  = idx_q;
    assign sts_wrap_count = wrap_q;
    assign sts_busy       = (state_q != S_IDLE);

    always_ff @(posedge clk_clk) begin
        if (push) mem_q[wr_ptr_q] <= snk_data;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        state_d  = state_q;
        beat_d   = beat_q;
        base_d   = base_q;
        num_d    = num_q;
        idx_d    = idx_q;
        wrap_d   = wrap_q;
        addr_d   = addr_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                count_d  = '0;
                idx_d    = '0;
                if (cfg_enable) begin
                    base_d  = cfg_base_addr;
                    num_d   = (cfg_num_bursts == 16'd0) ? 16'd1 : cfg_num_bursts;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                addr_d = base_q + {16'b0, idx_q} * BURST_BYTES;
                if (!cfg_enable) begin
                    // Residual partial-burst data is dropped on stop.
                    state_d  = S_IDLE;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                    idx_d    = '0;
                end else if (count_q >= (FIFO_AW+1)'(BURST_LEN)) begin
                    state_d = S_BURST;
                    beat_d  = '0;
                end
            end
            S_BURST: begin
                if (pop) beat_d = beat_q + 1'b1;
                if (last_beat) begin
                    state_d = S_FILL;
                    if (idx_q == num_q - 16'd1) begin
                        idx_d  = '0;
                        wrap_d = wrap_q + 16'd1;
                    end else begin
                        idx_d = idx_q + 16'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
            beat_q   <= '0;
            base_q   <= '0;
            num_q    <= 16'd1;
            idx_q    <= '0;
            wrap_q   <= '0;
            addr_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            beat_q   <= beat_d;
            base_q   <= base_d;
            num_q    <= num_d;
            idx_q    <= idx_d;
            wrap_q   <= wrap_d;
            addr_q   <= addr_d;
        end
    end
endmodule

// File: tb/tb_stream_ddr_burst_writer.sv
// Bench for stream_ddr_burst_writer: a queue-based transaction model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_stream_ddr_burst_writer;
    logic        clk_clk = 1'b0;
    logic        reset_reset;
    logic        cfg_enable;
    logic [31:0] cfg_base_addr;
    logic [15:0] cfg_num_bursts;
    logic [31:0] snk_data;
    logic        snk_valid;
    logic        snk_ready;
    logic [31:0] avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [3:0]  avm_burstcount;
    logic        avm_waitrequest;
    logic [15:0] sts_burst_idx;
    logic [15:0] sts_wrap_count;
    logic        sts_busy;

    stream_ddr_burst_writer #(.DATA_W(32), .BURST_LEN(8), .FIFO_AW(6)) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .cfg_enable(cfg_enable),
        .cfg_base_addr(cfg_base_addr), .cfg_num_bursts(cfg_num_bursts),
        .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
        .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_byteenable(avm_byteenable), .avm_burstcount(avm_burstcount),
        .avm_waitrequest(avm_waitrequest), .sts_burst_idx(sts_burst_idx),
        .sts_wrap_count(sts_wrap_count), .sts_busy(sts_busy)
    );

    always #5 clk_clk = ~clk_clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: accepted-but-unwritten samples, slot index, wrap count.
    logic [31:0] sq[$];
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    bit          m_run = 0;
    logic [31:0] m_base = '0;
    int          m_num = 1;
    int          m_idx = 0;
    logic [15:0] m_wrap = '0;
    int          beats_in = 0;
    int          total_beats = 0;
    int          acc_total = 0;
    int          discarded = 0;

    always @(negedge clk_clk) begin
        if (reset_reset) begin
            sq.delete();
            m_run = 0; m_idx = 0; m_wrap = '0; beats_in = 0;
        end else begin
            chk("busy", sts_busy, m_run);
            chk("snk_ready", snk_ready, m_run && (sq.size() < 64));
            chk("byteenable", avm_byteenable, 4'hF);
            chk("burstcount", avm_burstcount, 4'd8);
            chk("burst_idx", sts_burst_idx, m_idx);
            chk("wrap_count", sts_wrap_count, m_wrap);
            if (!m_run) chk("write_when_stopped", avm_write, 1'b0);
            if (beats_in != 0) chk("write_held_mid_burst", avm_write, 1'b1);
            if (avm_write) begin
                if (sq.size() < 8 - beats_in)
                    chk("fifo_words_for_burst", sq.size(), 8 - beats_in);
                else begin
                    chk("address", avm_address, m_base + 32'(m_idx) * 32);
                    chk("writedata", avm_writedata, sq[0]);
                end
            end
            if (snk_valid && snk_ready) begin
                sq.push_back(snk_data);
                acc_total++;
            end
            if (avm_write && !avm_waitrequest && sq.size() > 0) begin
                log_addr.push_back(avm_address);
                log_data.push_back(sq.pop_front());
                beats_in++;
                total_beats++;
                if (beats_in == 8) begin
                    beats_in = 0;
                    if (m_idx == m_num - 1) begin
                        m_idx = 0;
                        m_wrap = m_wrap + 16'd1;
                    end else m_idx = m_idx + 1;
                end
            end else if (m_run && !cfg_enable && beats_in == 0) begin
                m_run = 0;
                discarded = sq.size();
                sq.delete();
                m_idx = 0;
            end else if (!m_run && cfg_enable) begin
                m_run = 1;
                m_base = cfg_base_addr;
                m_num = (cfg_num_bursts == 0) ? 1 : int'(cfg_num_bursts);
            end
        end
    end

    int wr_mode = 0;   // 0 never stall, 1 random 50%, 2 always stall
    initial begin
        avm_waitrequest = 1'b0;
        forever begin
            @(posedge clk_clk); #1;
            case (wr_mode)
                1:       avm_waitrequest = 1'($urandom_range(0, 1));
                2:       avm_waitrequest = 1'b1;
                default: avm_waitrequest = 1'b0;
            endcase
        end
    end

    task automatic send(input int n, input logic [31:0] first);
        int  waited;
        bit  acc;
        for (int i = 0; i < n; i++) begin
            snk_data  = first + 32'(i);
            snk_valid = 1'b1;
            waited = 0;
            do begin
                @(negedge clk_clk);
                acc = snk_ready;
                @(posedge clk_clk); #1;
                waited++;
            end while (!acc && waited < 400);
            if (!acc) begin
                tests++; fails++;
                $display("FAIL send_timeout: word %0d not accepted, required acceptance", i);
                break;
            end
        end
        snk_valid = 1'b0;
    endtask

    task automatic wait_beats(input int target);
        int n;
        n = 0;
        while (total_beats < target && n < 1000) begin
            @(posedge clk_clk); #1;
            n++;
        end
        if (total_beats < target) begin
            tests++; fails++;
            $display("FAIL wait_beats: got %0d beats, required %0d", total_beats, target);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sts_busy && n < 200) begin
            @(posedge clk_clk); #1;
            n++;
        end
        chk("reach_idle", sts_busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    int start_beats;
    int start_acc;
    initial begin
        reset_reset = 1'b1;
        cfg_enable = 1'b0; cfg_base_addr = 32'h3000_0000; cfg_num_bursts = 16'd4;
        snk_data = '0; snk_valid = 1'b0;
        repeat (3) @(posedge clk_clk);
        #1;
        chk("rst_write", avm_write, 1'b0);
        chk("rst_ready", snk_ready, 1'b0);
        chk("rst_addr", avm_address, 32'h0);
        chk("rst_wdata", avm_writedata, 32'h0);
        chk("rst_idx", sts_burst_idx, 16'h0);
        chk("rst_wrap", sts_wrap_count, 16'h0);
        chk("rst_busy", sts_busy, 1'b0);
        reset_reset = 1'b0;
        repeat (2) @(posedge clk_clk);
        #1;

        // Four bursts of 0..31, one full pass through the buffer.
        cfg_enable = 1'b1;
        send(32, 32'd0);
        wait_beats(32);
        repeat (3) @(posedge clk_clk);
        #1;
        for (int b = 0; b < 4; b++)
            chk("t1_burst_addr", log_addr[b*8], 32'h3000_0000 + 32'(b) * 32'h20);
        for (int i = 0; i < 32; i++)
            chk("t1_data_order", log_data[i], 32'(i));
        chk("t1_idx", sts_burst_idx, 16'd0);
        chk("t1_wrap", sts_wrap_count, 16'd1);

        // Words 32..39 land back at the buffer start.
        send(8, 32'd32);
        wait_beats(40);
        repeat (3) @(posedge clk_clk);
        #1;
        chk("t2_addr", log_addr[32], 32'h3000_0000);
        chk("t2_addr_last", log_addr[39], 32'h3000_0000);
        for (int i = 32; i < 40; i++)
            chk("t2_data", log_data[i], 32'(i));
        chk("t2_idx", sts_burst_idx, 16'd1);
        chk("t2_wrap", sts_wrap_count, 16'd1);
        cfg_enable = 1'b0;
        wait_idle();
        chk("t2_idx_after_stop", sts_burst_idx, 16'd0);

        // Random stalls across 16 words.
        wr_mode = 1;
        start_beats = total_beats;
        cfg_enable = 1'b1;
        send(16, 32'd100);
        wait_beats(start_beats + 16);
        repeat (4) @(posedge clk_clk);
        #1;
        chk("t3_beats", total_beats - start_beats, 16);
        for (int i = 0; i < 16; i++)
            chk("t3_data", log_data[start_beats + i], 32'd100 + 32'(i));
        chk("t3_idx", sts_burst_idx, 16'd2);
        wr_mode = 0;
        cfg_enable = 1'b0;
        wait_idle();

        // Permanent stall: FIFO fills to 64 and backpressures.
        wr_mode = 2;
        start_beats = total_beats;
        start_acc = acc_total;
        cfg_enable = 1'b1;
        fork
            send(100, 32'd200);
            begin
                repeat (150) @(posedge clk_clk);
                #1;
                chk("t4_accepted_at_full", acc_total - start_acc, 64);
                chk("t4_ready_low", snk_ready, 1'b0);
                chk("t4_no_beats", total_beats - start_beats, 0);
                wr_mode = 0;
            end
        join
        wait_beats(start_beats + 96);
        repeat (3) @(posedge clk_clk);
        #1;
        for (int i = 0; i < 96; i++)
            chk("t4_data", log_data[start_beats + i], 32'd200 + 32'(i));
        chk("t4_wrap", sts_wrap_count, 16'd4);
        chk("t4_idx", sts_burst_idx, 16'd0);
        cfg_enable = 1'b0;
        wait_idle();
        chk("t4_discarded", discarded, 4);

        // Stop during beat 3 with five words waiting behind the burst.
        start_beats = total_beats;
        cfg_enable = 1'b1;
        fork
            send(13, 32'd300);
            begin
                int n;
                n = 0;
                while (total_beats < start_beats + 3 && n < 200) begin
                    @(posedge clk_clk); #1;
                    n++;
                end
                cfg_enable = 1'b0;
            end
        join
        wait_idle();
        repeat (2) @(posedge clk_clk);
        #1;
        chk("t5_beats", total_beats - start_beats, 8);
        chk("t5_last_data", log_data[start_beats + 7], 32'd307);
        chk("t5_discarded", discarded, 5);
        chk("t5_idx", sts_burst_idx, 16'd0);
        chk("t5_busy", sts_busy, 1'b0);
        chk("t5_wrap", sts_wrap_count, 16'd4);

        // Asynchronous reset in the middle of a burst.
        start_beats = total_beats;
        cfg_enable = 1'b1;
        send(12, 32'd400);
        wait_beats(start_beats + 4);
        chk("t6_mid_burst", avm_write, 1'b1);
        #2;
        reset_reset = 1'b1;
        #1;
        chk("t6_write", avm_write, 1'b0);
        chk("t6_ready", snk_ready, 1'b0);
        chk("t6_idx", sts_burst_idx, 16'd0);
        chk("t6_wrap", sts_wrap_count, 16'd0);
        chk("t6_busy", sts_busy, 1'b0);
        chk("t6_addr", avm_address, 32'h0);
        cfg_enable = 1'b0;
        repeat (2) @(posedge clk_clk);
        #1;
        reset_reset = 1'b0;
        repeat (3) @(posedge clk_clk);
        #1;
        chk("t6_post_busy", sts_busy, 1'b0);
        chk("t6_post_wrap", sts_wrap_count, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
